// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        WRITE = 2'b10,
        RUN   = 2'b11
    } state_t;

    localparam int unsigned BYTE_CNT_W = 2;
    localparam logic [31:0] DEFAULT_BASE_ADR = 32'h0000_0000;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 8->32 packer: bytes shift in MSB first; word_valid marks the 4th byte.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BYTE_CNT_W-1:0] byte_cnt;

    assign word_valid = accept && !flush && (byte_cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (flush) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word     <= {word[23:0], in_data};
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: holds the MIPS core in reset, streams an image into memory,
// then releases the core and hands it the memory port.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR  = DEFAULT_BASE_ADR,
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] load_len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] core_adr,
    input  logic [31:0] core_writedata,
    input  logic        core_memwrite,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_writedata,
    output logic        mem_memwrite,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_t              state, state_next;
    logic [15:0]         len, word_idx;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [31:0]         word;
    logic                word_valid;
    logic                accept, start_acc, too_big, last_word, timeout_hit, flush;

    assign accept      = in_valid && (state == LOAD);
    assign start_acc   = start && ((state == IDLE) || (state == RUN));
    assign too_big     = 32'(load_len) > MAX_WORDS;
    assign last_word   = word_idx == (len - 16'd1);
    assign timeout_hit = (state == LOAD) && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign flush       = start_acc || timeout_hit;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (reset),
        .flush      (flush),
        .accept     (accept),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            word_idx <= '0;
            idle_cnt <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                len      <= load_len;
                error    <= too_big;
                word_idx <= '0;
                idle_cnt <= '0;
            end else if (state == LOAD) begin
                if (accept || timeout_hit)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                if (timeout_hit)
                    error <= 1'b1;
            end else if (state == WRITE) begin
                word_idx <= word_idx + 16'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        core_reset    = 1'b1;
        mem_adr       = BASE_ADR + {14'd0, word_idx, 2'b00};
        mem_writedata = word;
        mem_memwrite  = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (state == RUN) begin
                    // Port ownership and core release switch together.
                    core_reset    = 1'b0;
                    done          = 1'b1;
                    mem_adr       = core_adr;
                    mem_writedata = core_writedata;
                    mem_memwrite  = core_memwrite;
                end
                if (start_acc) begin
                    if (load_len == 16'd0)
                        state_next = RUN;
                    else if (too_big)
                        state_next = IDLE;
                    else
                        state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (word_valid)
                    state_next = WRITE;
                else if (timeout_hit)
                    state_next = IDLE;
            end
            WRITE: begin
                busy         = 1'b1;
                mem_memwrite = 1'b1;
                state_next   = last_word ? RUN : LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: expected memory writes come from a byte-level image model.
module tb_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] load_len = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] core_adr = '0;
    logic [31:0] core_writedata = '0;
    logic        core_memwrite = 1'b0;
    logic [31:0] mem_adr, mem_writedata;
    logic        mem_memwrite, core_reset, busy, done, error;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;

    // Image model: bytes collected MSB first; every 4th byte yields a write to BASE+4*idx.
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] m_word;
    int          m_cnt, m_idx;

    mem_loader #(.BASE_ADR(BASE), .MAX_WORDS(64), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_adr(core_adr), .core_writedata(core_writedata), .core_memwrite(core_memwrite),
        .mem_adr(mem_adr), .mem_writedata(mem_writedata), .mem_memwrite(mem_memwrite),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_word = '0;
        m_cnt  = 0;
        m_idx  = 0;
    endtask

    // Advance one cycle and check the port against the ownership rules and the write model.
    task automatic step();
        @(posedge clk);
        #1;
        if (!core_reset) begin
            chk("run_adr", mem_adr, core_adr);
            chk("run_wdata", mem_writedata, core_writedata);
            chk("run_we", 32'(mem_memwrite), 32'(core_memwrite));
            chk("run_done", 32'(done), 1);
            chk("run_busy", 32'(busy), 0);
        end else begin
            chk("held_done", 32'(done), 0);
            if (in_ready) chk("ready_busy", 32'(busy), 1);
            if (mem_memwrite) begin
                n_writes++;
                if (exp_adr_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_memwrite), 0);
                end else begin
                    chk("write_adr", mem_adr, exp_adr_q.pop_front());
                    chk("write_data", mem_writedata, exp_dat_q.pop_front());
                end
            end
        end
        core_adr       = $urandom;
        core_writedata = $urandom;
        core_memwrite  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input logic [15:0] len, input bit accepted);
        load_len = len;
        start    = 1'b1;
        if (accepted) model_clear();
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk("ready_wait", 32'(in_ready), 1);
        if (in_ready) begin
            m_word = {m_word[23:0], b};
            m_cnt++;
            if (m_cnt == 4) begin
                exp_adr_q.push_back(BASE + 32'(m_idx) * 32'd4);
                exp_dat_q.push_back(m_word);
                m_idx++;
                m_cnt = 0;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int w0;
        logic [7:0] img [8];
        img = '{8'h20, 8'h02, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00};
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_we", 32'(mem_memwrite), 0);
        reset = 1'b0;
        step();

        // Two-word load
        w0 = n_writes;
        do_start(16'd2, 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        chk("t1_w0_we", 32'(mem_memwrite), 1);
        chk("t1_w0_adr", mem_adr, 32'h0000_0000);
        chk("t1_w0_data", mem_writedata, 32'h2002_0005);
        for (int i = 4; i < 8; i++) send_byte(img[i]);
        chk("t1_w1_adr", mem_adr, 32'h0000_0004);
        chk("t1_w1_data", mem_writedata, 32'hAC02_0000);
        chk("t1_held_in_write", 32'(core_reset), 1);
        step();
        chk("t1_released", 32'(core_reset), 0);
        chk("t1_done", 32'(done), 1);
        chk("t1_nwrites", 32'(n_writes - w0), 2);

        // Port mux in RUN
        core_adr = 32'h44; core_writedata = 32'h7; core_memwrite = 1'b1;
        #1;
        chk("t2_run_adr", mem_adr, 32'h44);
        chk("t2_run_wdata", mem_writedata, 32'h7);
        chk("t2_run_we", 32'(mem_memwrite), 1);

        // Oversize length
        w0 = n_writes;
        do_start(16'd65, 1);
        chk("t3_error", 32'(error), 1);
        chk("t3_ready", 32'(in_ready), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_core_reset", 32'(core_reset), 1);
        core_adr = 32'h44; core_writedata = 32'h7; core_memwrite = 1'b1;
        #1;
        chk("t3_idle_we", 32'(mem_memwrite), 0);
        step();
        chk("t3_nwrites", 32'(n_writes - w0), 0);

        // Timeout after a partial word
        do_start(16'd1, 1);
        chk("t4_err_cleared", 32'(error), 0);
        send_byte(8'h11);
        send_byte(8'h22);
        w0 = n_writes;
        for (int i = 0; i < 1023; i++) step();
        chk("t4_pre_busy", 32'(busy), 1);
        chk("t4_pre_error", 32'(error), 0);
        step();
        chk("t4_error", 32'(error), 1);
        chk("t4_idle", 32'(busy), 0);
        chk("t4_nwrites", 32'(n_writes - w0), 0);
        model_clear();

        // Reset in the middle of a 3-word load
        do_start(16'd3, 1);
        chk("t5_err_cleared", 32'(error), 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        reset = 1'b1;
        #1;
        chk("t5_core_reset", 32'(core_reset), 1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ready", 32'(in_ready), 0);
        chk("t5_queue", 32'(exp_adr_q.size()), 0);
        step();
        reset = 1'b0;
        step();
        do_start(16'd1, 1);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("t5_adr", mem_adr, BASE);
        chk("t5_data", mem_writedata, 32'hDEAD_BEEF);
        step();
        chk("t5_done", 32'(done), 1);

        // Zero length from IDLE
        do_start(16'd65, 1);
        w0 = n_writes;
        do_start(16'd0, 1);
        chk("t6_core_reset", 32'(core_reset), 0);
        chk("t6_done", 32'(done), 1);
        chk("t6_error", 32'(error), 0);
        repeat (3) step();
        chk("t6_nwrites", 32'(n_writes - w0), 0);

        // start during LOAD is ignored
        do_start(16'd2, 1);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
        do_start(16'd5, 0);
        chk("t7_still_busy", 32'(busy), 1);
        send_byte(8'h35); send_byte(8'h36); send_byte(8'h37);
        chk("t7_w1_adr", mem_adr, 32'h0000_0004);
        chk("t7_w1_data", mem_writedata, 32'h3435_3637);
        step();
        chk("t7_done", 32'(done), 1);
        repeat (2) step();

        chk("final_queue_empty", 32'(exp_adr_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
